lcd_cmd_arbiter: RTL and testbench
==================================

# lcd_cmd_arbiter

Shares the single LCD_Controller command port (iData/iRS/iStart/oDone handshake) between N_REQ independent requesters, e.g. the init/text LUT sequencer and a live status writer. Round-robin arbitration picks one 9-bit command {RS, DATA}, drives it to the controller, and waits for completion. It then enforces a post-command settle delay before the next grant, and returns a one-cycle acknowledge to the winning requester.

## Interface
- N_REQ, 2: number of requesters (2..8)
- DLY_CYCLES, 18'h3FFFE: settle cycles after each completed command (≥1)
- DLY_W, 18: settle counter width; DLY_CYCLES < 2^DLY_W
- iCLK  in  1  single clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iReq  in  N_REQ  per-requester command request, level, held until oAck
- iData  in  8*N_REQ  command byte of requester i at [8i+7:8i]
- iRS  in  N_REQ  register-select of requester i
- iLock  in  N_REQ  keep grant for next command (LCD_ARB_LOCK_EN only; else ignored)
- oAck  out  N_REQ  one-hot, one-cycle pulse: requester's command completed
- oBusy  out  1  high whenever state ≠ IDLE
- oLCD_Data  out  8  to controller iData
- oLCD_RS  out  1  to controller iRS
- oLCD_Start  out  1  to controller iStart
- iLCD_Done  in  1  from controller oDone

## Operation
- Reset (iRST high at edge): state IDLE, oAck=0, oBusy=0, oLCD_Data=0, oLCD_RS=0, oLCD_Start=0, settle count=0, last-grant pointer=N_REQ-1 (requester 0 wins first).
- States: IDLE, WAIT_DONE, SETTLE.
- IDLE: if any iReq bit set, pick winner g = first set bit searching from (last+1) mod N_REQ upward with wrap; register oLCD_Data=iData[g], oLCD_RS=iRS[g], oLCD_Start=1, last=g; go WAIT_DONE. No request: stay.
- WAIT_DONE: hold oLCD_Start/Data/RS stable. On iLCD_Done=1: oLCD_Start<=0, oAck[g]<=1 (one cycle), count<=0, go SETTLE.
- SETTLE: count increments each cycle; when count==DLY_CYCLES-1 go IDLE. iLCD_Done ignored here.
- iLCD_Done in IDLE or SETTLE is ignored; no ack, no state change.
- Data captured only at grant; requester changes to iData/iRS after grant have no effect on the command in flight.
- Requester dropping iReq before oAck does not abort the command; ack is still issued.
- Requester keeping iReq high after oAck is treated as a new command in the next IDLE.
- oLCD_Data/oLCD_RS retain last command values after completion (not cleared).

## Timing
- Grant latency: iReq sampled in IDLE at edge t → oLCD_Start=1 with data valid after edge t (visible cycle t+1).
- Done → Start low and oAck high both after the same edge; oAck high exactly one cycle.
- Settle: IDLE re-entered exactly DLY_CYCLES cycles after oAck rises; next oLCD_Start earliest DLY_CYCLES+1 cycles after oAck.
- Minimum command period = 1 + controller latency + 1 + DLY_CYCLES cycles.
- Reset mid-operation: next edge forces all reset values; in-flight command abandoned, no oAck.

## Configuration
- LCD_ARB_LOCK_EN defined: in IDLE, if iLock[last] and iReq[last] both high, last is re-granted regardless of round-robin order (multi-byte sequences such as set-address then characters stay atomic). Lock with iReq[last] low is ignored.
- Undefined: iLock unused, pure round-robin.

## Structure
- Shared package lcd_pkg: state enum (IDLE, WAIT_DONE, SETTLE), LCD_DLY_DEFAULT = 18'h3FFFE, command-field widths (data 8, RS 1).
- Sub-module lcd_rr_pick: combinational round-robin picker (iReq, last pointer → one-hot grant + index); reused by any future shared-resource arbiter.

## Test plan
- Reset: hold iRST 2 cycles with iReq=2'b11 → all outputs 0; after release requester 0 granted first.
- Single: DLY_CYCLES=4, iReq=01, iData[7:0]=8'h41, iRS[0]=1 → next cycle oLCD_Start=1, oLCD_Data=8'h41, oLCD_RS=1; Done pulse → Start 0 and oAck=01 for one cycle, oBusy high 4 more cycles, then 0.
- Fairness: iReq=11 held, controller Done 3 cycles after each Start → grants 0,1,0,1; oAck alternates 01,10.
- Lock (LCD_ARB_LOCK_EN): iReq=11, iLock=01 for 3 commands → three consecutive oAck=01; iLock=0 → next oAck=10. Without macro → alternation.
- Reset mid WAIT_DONE: assert iRST while oLCD_Start=1 → Start 0 next cycle, no oAck; requester 0 granted first after release.
- Spurious Done: iLCD_Done=1 in IDLE and SETTLE → no oAck, no state change, settle length unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD command-port definitions: arbiter state encoding, default settle
// delay and command field widths.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    SETTLE
  } lcd_state_t;

  localparam logic [17:0] LCD_DLY_DEFAULT = 18'h3FFFE;

  localparam int unsigned LCD_DATA_W = 8;
  localparam int unsigned LCD_RS_W   = 1;
  localparam int unsigned LCD_CMD_W  = LCD_DATA_W + LCD_RS_W;

  typedef struct packed {
    logic [LCD_RS_W-1:0]   rs;
    logic [LCD_DATA_W-1:0] data;
  } lcd_cmd_t;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after i_last, wrapping around. Returns one-hot grant and index.
module lcd_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    // Offset 1..N visits every slot once, ending on i_last itself.
    for (int unsigned off = 1; off <= N; off++) begin
      w_k = IDX_W'((32'(i_last) + off) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_idx      = w_k;
        o_grant[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin sharing of the LCD_Controller command port between N_REQ
// requesters with post-command settle delay. Optional macro: LCD_ARB_LOCK_EN.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DLY_CYCLES = LCD_DLY_DEFAULT,
  parameter int unsigned DLY_W      = 18
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [N_REQ-1:0]            iReq,
  input  logic [LCD_DATA_W*N_REQ-1:0] iData,
  input  logic [N_REQ-1:0]            iRS,
  input  logic [N_REQ-1:0]            iLock,
  output logic [N_REQ-1:0]            oAck,
  output logic                        oBusy,
  output logic [LCD_DATA_W-1:0]       oLCD_Data,
  output logic                        oLCD_RS,
  output logic                        oLCD_Start,
  input  logic                        iLCD_Done
);

  localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  lcd_state_t            r_state;
  logic [N_REQ-1:0]      r_ack;
  logic [N_REQ-1:0]      r_gnt;
  logic [IDX_W-1:0]      r_last;
  logic [DLY_W-1:0]      r_cnt;
  lcd_cmd_t              r_cmd;
  logic                  r_start;

  logic [N_REQ-1:0]      w_pick_oh;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_valid;
  logic                  w_lock_hit;
  logic [N_REQ-1:0]      w_win_oh;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_any;
  logic [LCD_DATA_W-1:0] w_data [N_REQ];

  lcd_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (iReq),
    .i_last  (r_last),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

`ifdef LCD_ARB_LOCK_EN
  assign w_lock_hit = iLock[r_last] & iReq[r_last];
`else
  logic w_unused_lock;
  assign w_lock_hit    = 1'b0;
  assign w_unused_lock = ^iLock;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_data[i] = iData[LCD_DATA_W*i +: LCD_DATA_W];
    end
  end

  // A held lock overrides round-robin and re-grants the previous winner.
  always_comb begin
    w_win_oh  = w_pick_oh;
    w_win_idx = w_pick_idx;
    w_any     = w_pick_valid;
    if (w_lock_hit) begin
      w_win_oh         = '0;
      w_win_oh[r_last] = 1'b1;
      w_win_idx        = r_last;
      w_any            = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_gnt   <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_start <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cmd.data <= w_data[w_win_idx];
            r_cmd.rs   <= iRS[w_win_idx];
            r_start    <= 1'b1;
            r_gnt      <= w_win_oh;
            r_last     <= w_win_idx;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (iLCD_Done) begin
            r_start <= 1'b0;
            r_ack   <= r_gnt;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == DLY_LAST) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oAck       = r_ack;
  assign oBusy      = (r_state != IDLE);
  assign oLCD_Data  = r_cmd.data;
  assign oLCD_RS    = r_cmd.rs;
  assign oLCD_Start = r_start;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter (N_REQ=2, DLY_CYCLES=4); the lock
// scenario expectation follows LCD_ARB_LOCK_EN.
module tb_lcd_cmd_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [1:0]  iReq;
  logic [15:0] iData;
  logic [1:0]  iRS;
  logic [1:0]  iLock;
  logic [1:0]  oAck;
  logic        oBusy;
  logic [7:0]  oLCD_Data;
  logic        oLCD_RS;
  logic        oLCD_Start;
  logic        iLCD_Done;

  int checks = 0;
  int errors = 0;

  lcd_cmd_arbiter #(
    .N_REQ      (2),
    .DLY_CYCLES (4),
    .DLY_W      (18)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iReq       (iReq),
    .iData      (iData),
    .iRS        (iRS),
    .iLock      (iLock),
    .oAck       (oAck),
    .oBusy      (oBusy),
    .oLCD_Data  (oLCD_Data),
    .oLCD_RS    (oLCD_RS),
    .oLCD_Start (oLCD_Start),
    .iLCD_Done  (iLCD_Done)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic apply_reset();
    iRST = 1'b1; iReq = 2'b00; iLock = 2'b00; iLCD_Done = 1'b0;
    tick(); tick();
    iRST = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (oLCD_Start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1; iReq = 2'b11; iData = 16'h2211; iRS = 2'b01;
    iLock = 2'b00; iLCD_Done = 1'b0;
    tick(); tick();
    checks++;
    if ({oLCD_Start, oLCD_RS, oBusy, oAck, oLCD_Data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b rs=%b busy=%b ack=%b data=%h exp all 0",
               oLCD_Start, oLCD_RS, oBusy, oAck, oLCD_Data);
    end
    iRST = 1'b0;
    tick();
    checks++;
    if (oLCD_Start !== 1'b1 || oLCD_Data !== 8'h11 || oLCD_RS !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got start=%b data=%h rs=%b exp 1 11 1",
               oLCD_Start, oLCD_Data, oLCD_RS);
    end
  endtask

  task automatic test_single();
    apply_reset();
    iReq = 2'b01; iData = 16'h0041; iRS = 2'b01;
    tick();
    checks++;
    if (oLCD_Start !== 1'b1 || oLCD_Data !== 8'h41 || oLCD_RS !== 1'b1 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got start=%b data=%h rs=%b busy=%b exp 1 41 1 1",
               oLCD_Start, oLCD_Data, oLCD_RS, oBusy);
    end
    iData = 16'h0099; iRS = 2'b00; iReq = 2'b00;
    tick(); tick();
    checks++;
    if (oLCD_Start !== 1'b1 || oLCD_Data !== 8'h41 || oLCD_RS !== 1'b1 || oAck !== 2'b00) begin
      errors++;
      $display("FAIL single_hold got start=%b data=%h rs=%b ack=%b exp 1 41 1 00",
               oLCD_Start, oLCD_Data, oLCD_RS, oAck);
    end
    iLCD_Done = 1'b1;
    tick();
    iLCD_Done = 1'b0;
    checks++;
    if (oLCD_Start !== 1'b0 || oAck !== 2'b01 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack got start=%b ack=%b busy=%b exp 0 01 1", oLCD_Start, oAck, oBusy);
    end
    tick();
    checks++;
    if (oAck !== 2'b00) begin
      errors++;
      $display("FAIL single_ack_width got %b exp 00", oAck);
    end
    tick(); tick();
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL single_settle_busy got %b exp 1", oBusy);
    end
    tick();
    checks++;
    if (oBusy !== 1'b0 || oLCD_Data !== 8'h41 || oLCD_RS !== 1'b1 || oLCD_Start !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b data=%h rs=%b start=%b exp 0 41 1 0",
               oBusy, oLCD_Data, oLCD_RS, oLCD_Start);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [1:0] exp_ack;
    logic [7:0] exp_data;
    apply_reset();
    iData = 16'hB2A1; iRS = 2'b10; iReq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ack  = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_data = (i % 2 == 1) ? 8'hB2 : 8'hA1;
      wait_start(ok);
      checks++;
      if (!ok || oLCD_Data !== exp_data) begin
        errors++;
        $display("FAIL fair_grant%0d got started=%b data=%h exp 1 %h", i, ok, oLCD_Data, exp_data);
      end
      tick(); tick();
      iLCD_Done = 1'b1;
      tick();
      iLCD_Done = 1'b0;
      checks++;
      if (oAck !== exp_ack) begin
        errors++;
        $display("FAIL fair_ack%0d got %b exp %b", i, oAck, exp_ack);
      end
    end
    iReq = 2'b00;
  endtask

  task automatic test_lock();
    bit ok;
    logic [1:0] exp_l [4];
`ifdef LCD_ARB_LOCK_EN
    exp_l = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    exp_l = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    apply_reset();
    iData = 16'h2F1E; iRS = 2'b00; iReq = 2'b11; iLock = 2'b01;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL lock_start%0d got no start exp start", i);
      end
      tick();
      iLCD_Done = 1'b1;
      tick();
      iLCD_Done = 1'b0;
      if (i == 2) iLock = 2'b00;
      checks++;
      if (oAck !== exp_l[i]) begin
        errors++;
        $display("FAIL lock_ack%0d got %b exp %b", i, oAck, exp_l[i]);
      end
    end
    iReq = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    iData = 16'hC35A; iRS = 2'b00; iReq = 2'b01;
    wait_start(ok);
    checks++;
    if (!ok || oLCD_Data !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_grant got started=%b data=%h exp 1 5a", ok, oLCD_Data);
    end
    iReq = 2'b11; iRST = 1'b1; iLCD_Done = 1'b1;
    tick();
    checks++;
    if (oLCD_Start !== 1'b0 || oAck !== 2'b00 || oBusy !== 1'b0 || oLCD_Data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_abort got start=%b ack=%b busy=%b data=%h exp 0 00 0 00",
               oLCD_Start, oAck, oBusy, oLCD_Data);
    end
    iRST = 1'b0; iLCD_Done = 1'b0;
    tick();
    checks++;
    if (oLCD_Start !== 1'b1 || oLCD_Data !== 8'h5A || oAck !== 2'b00) begin
      errors++;
      $display("FAIL midrst_regrant got start=%b data=%h ack=%b exp 1 5a 00",
               oLCD_Start, oLCD_Data, oAck);
    end
  endtask

  task automatic test_spurious_done();
    int busy_cycles;
    apply_reset();
    iData = 16'h0077; iRS = 2'b00;
    iLCD_Done = 1'b1;
    tick(); tick();
    checks++;
    if (oAck !== 2'b00 || oBusy !== 1'b0 || oLCD_Start !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle got ack=%b busy=%b start=%b exp 00 0 0", oAck, oBusy, oLCD_Start);
    end
    iLCD_Done = 1'b0; iReq = 2'b01;
    tick();
    iReq = 2'b00;
    tick();
    iLCD_Done = 1'b1;
    tick();
    checks++;
    if (oAck !== 2'b01) begin
      errors++;
      $display("FAIL spur_cmd_ack got %b exp 01", oAck);
    end
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (oBusy !== 1'b1) break;
      busy_cycles++;
      tick();
      if (oAck !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL spur_settle_ack got %b exp 00", oAck);
      end
    end
    checks++;
    if (busy_cycles != 4) begin
      errors++;
      $display("FAIL spur_settle_len got %0d exp 4", busy_cycles);
    end
    tick();
    iLCD_Done = 1'b0;
    checks++;
    if (oAck !== 2'b00 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL spur_after got ack=%b busy=%b exp 00 0", oAck, oBusy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_reset_mid();
    test_spurious_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
